// File: rtl/ncl_alu_driver.sv
`default_nettype none
// ============================================================================
// Module   : ncl_alu_driver
// Purpose  : Boundary between the synchronous domain and the NCL ALU datapath.
//            Encodes single-rail operands/opcode as a dual-rail DATA wavefront,
//            waits for result completion, returns the rails to NULL, waits for
//            NULL completion, then hands the decoded result back over a
//            valid/ready handshake.
//            Dual-rail pair: bit[1] = true rail, bit[0] = false rail.
//            00 = NULL, 01 = DATA0, 10 = DATA1, 11 = illegal.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid/in_ready, in_a, in_b, in_op   - operand request
//            dr_a, dr_b, dr_sel0, dr_sel1           - dual-rail to NCL ALU
//            dr_res, dr_ovf                         - dual-rail from NCL ALU
//            out_valid/out_ready, out_res, out_ovf, out_err - result response
// Revision : 1.0 - initial release
// ============================================================================
module ncl_alu_driver #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [1:0]         in_op,
    output logic [2*WIDTH-1:0] dr_a,
    output logic [2*WIDTH-1:0] dr_b,
    output logic [1:0]         dr_sel0,
    output logic [1:0]         dr_sel1,
    input  logic [2*WIDTH-1:0] dr_res,
    input  logic [1:0]         dr_ovf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_res,
    output logic               out_ovf,
    output logic               out_err
);

    localparam int         NPAIR       = WIDTH + 1;   // result pairs + overflow pair
    localparam int         SW          = 2 * NPAIR;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_D = 2'd1,
        WAIT_N = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Two-stage sampler of the asynchronous return rails; layout {ovf, res}.
    logic [SW-1:0]    s1;
    logic [SW-1:0]    s2;
    logic [7:0]       cnt;

    logic             all_data;
    logic             all_null;
    logic             any_illegal;
    logic             stable;
    logic             data_done;
    logic             null_done;
    logic             timed_out;
    logic [WIDTH-1:0] res_dec;
    logic             ovf_dec;

    logic             accept;
    logic             capture;
    logic             to_data;
    logic             to_null;

    function automatic logic [2*WIDTH-1:0] enc(input logic [WIDTH-1:0] v);
        logic [2*WIDTH-1:0] e;
        for (int i = 0; i < WIDTH; i++) begin
            e[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        end
        return e;
    endfunction

    // Completion detection on the second sampling stage.
    always_comb begin
        all_data    = 1'b1;
        all_null    = 1'b1;
        any_illegal = 1'b0;
        for (int i = 0; i < NPAIR; i++) begin
            if (s2[2*i +: 2] == 2'b00) begin
                all_data = 1'b0;
            end else begin
                all_null = 1'b0;
            end
            if (s2[2*i +: 2] == 2'b11) begin
                any_illegal = 1'b1;
            end
        end
    end

    assign stable    = (s2 == s1);
    assign data_done = stable && all_data;
    assign null_done = stable && all_null;
    assign timed_out = (cnt == TIMEOUT_CNT);

    // An illegal 11 pair decodes to 0 (true rail masked by false rail).
    for (genvar i = 0; i < WIDTH; i++) begin : g_decode
        assign res_dec[i] = s2[2*i+1] & ~s2[2*i];
    end
    assign ovf_dec = s2[SW-1] & ~s2[SW-2];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        to_data   = 1'b0;
        to_null   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    accept    = 1'b1;
                    state_nxt = WAIT_D;
                end
            end
            WAIT_D: begin
                // Completion has priority over a coincident timeout.
                if (data_done) begin
                    capture   = 1'b1;
                    state_nxt = WAIT_N;
                end else if (timed_out) begin
                    to_data   = 1'b1;
                    state_nxt = WAIT_N;
                end
            end
            WAIT_N: begin
                if (null_done) begin
                    state_nxt = RESP;
                end else if (timed_out) begin
                    to_null   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------ Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            cnt     <= '0;
            dr_a    <= '0;
            dr_b    <= '0;
            dr_sel0 <= '0;
            dr_sel1 <= '0;
            out_res <= '0;
            out_ovf <= 1'b0;
            out_err <= 1'b0;
        end else begin
            s1 <= {dr_ovf, dr_res};
            s2 <= s1;

            // Counter restarts on every state change, so it always measures
            // time spent in the current wait state.
            cnt <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;

            if (accept) begin
                dr_a    <= enc(in_a);
                dr_b    <= enc(in_b);
                dr_sel0 <= in_op[0] ? 2'b10 : 2'b01;
                dr_sel1 <= in_op[1] ? 2'b10 : 2'b01;
                out_err <= 1'b0;
            end

            if (capture || to_data) begin
                dr_a    <= '0;
                dr_b    <= '0;
                dr_sel0 <= '0;
                dr_sel1 <= '0;
            end

            if (capture) begin
                out_res <= res_dec;
                out_ovf <= ovf_dec;
                out_err <= any_illegal;
            end

            if (to_data) begin
                out_res <= '0;
                out_ovf <= 1'b0;
                out_err <= 1'b1;
            end

            if (to_null) begin
                out_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
